ssi_encoder_emulator: RTL
=========================

Name: ssi_encoder_emulator

Overview:
- SSI slave that emulates the motor absolute encoder: it answers the motor-control SSI master clock with a 28-bit frame.
- Frame layout: 19-bit position, 3-bit status, 6-bit inverted CRC (polynomial x^6+x+1, seed 6'h01).
- Used for hardware-in-the-loop and self-test: a motor channel's ssi_c/ssi_d pins are looped to this block instead of a physical encoder.
- Position/status come from SPI-written registers in the top level; a CRC error can be injected to exercise the master's CRC error counter.

Parameters:
- FRAME_BITS, 28, total bits per frame (19 position + 3 status + 6 CRC).
- POS_BITS, 19, position field width.
- MONOFLOP_TICKS, 150, clk_100m cycles without an ssi_c edge before the slave releases ssi_d high (1.5 us).
- CRC_SEED, 6'h01, CRC register init value.

Ports:
- clk_100m  in  1  system clock, 100 MHz
- rst_n_syn  in  1  reset, asynchronous, active-low
- enable  in  1  when 0, the block ignores ssi_c and holds ssi_d=1
- position_in  in  19  position sampled at frame start
- status_in  in  3  status bits sampled at frame start
- crc_err_inj  in  1  when 1 at frame latch, transmitted CRC bit 0 is inverted
- ssi_c  in  1  SSI clock from master (asynchronous; idles high)
- ssi_d  out  1  SSI data to master (idles high)
- busy  out  1  high from latch until monoflop expiry
- frame_cnt  out  16  completed frames (28 bits shifted), wraps
- abort_cnt  out  16  frames ended by timeout before bit 28, wraps

Behaviour:
- Reset values: ssi_d=1, busy=0, frame_cnt=0, abort_cnt=0, state=IDLE.
- Input conditioning: ssi_c passes through a 2-FF synchronizer, then a third stage for edge detection. Edge detect latency is 3 clocks from the pin.
- The monoflop counter reloads to MONOFLOP_TICKS on every detected ssi_c edge. It decrements otherwise in the LATCHED, SHIFT and MONO states.
- States:
  - IDLE: ssi_d=1. A falling edge with enable=1 moves to LATCHED. Frame latch happens on that falling edge:
    - shift register = {position_in, status_in, crc6};
    - crc6 = ~CRC over the 22 data bits (MSB first) from CRC_SEED;
    - if crc_err_inj, crc6[0] is inverted;
    - bit index = 27.
  - LATCHED: the next rising edge drives ssi_d = shift[27] and goes to SHIFT. Timeout goes to MONO (counts as abort).
  - SHIFT: each rising edge drives the next lower bit. ssi_d is registered and changes 1 clock after edge detect.
    - When bit 0 has been driven, the next rising edge drives ssi_d=0, increments frame_cnt and goes to MONO.
    - Falling edges hold data.
    - Timeout before bit 0 increments abort_cnt and goes to MONO with ssi_d=0.
  - MONO: ssi_d=0. Further rising edges keep ssi_d=0 and reload the monoflop. On expiry: ssi_d=1, busy=0, go to IDLE.
- CRC step, per data bit d, 6-bit register c:
  - n0 = c5^d;
  - n1 = c0^c5^d;
  - n[5:2] = c[4:1].
  - The transmitted CRC is the bitwise inverse, MSB first. A master seeded with 6'h01 that feeds data bits raw and CRC bits inverted ends at 0.
- Timing budget: the master samples on its falling edge after 2 debounce FFs. Max ssi_d delay after an ssi_c rising edge is 4 clocks, which is well below the half period (13 clocks).
- Inputs position_in/status_in/crc_err_inj are sampled only at latch. Changes mid-frame do not affect the frame in flight.
- enable deasserted mid-frame: the frame aborts immediately, abort_cnt increments, ssi_d=1, state goes to IDLE.
- Counter wrap: frame_cnt and abort_cnt wrap 16'hFFFF -> 0.
- A falling edge and a timeout in the same clock: the edge wins (monoflop reloads).
- Reset mid-frame: asynchronous return to reset values; ssi_d=1 immediately.

Decomposition:
- Shared package additions to parameters_4mb.v:
  - nextCRCx43_D1 function (reused, not duplicated);
  - SSI_FRAME_BITS=28, SSI_POS_BITS=19, SSI_STATUS_BITS=3, SSI_CRC_SEED=6'h01;
  - state encodings SSI_EMU_IDLE/LATCHED/SHIFT/MONO.
- One natural sub-module, ssi_edge_sync: 3-FF synchronizer with rise/fall pulse outputs.
- The CRC is computed by looping nextCRCx43_D1 22 times combinationally at latch. No sub-module is needed for it.

Test Plan:
- Null frame: position_in=0, status_in=0, master-model clock period 26 clocks -> bits 28'h000000A (CRC 0x35 inverted to 0x0A). frame_cnt=1, ssi_d returns to 1 after 150 idle clocks.
- Loop to a master with the same clocking, position_in=19'h5A5A5, status_in=3'b101 -> master position field 19'h5A5A5, status 3'b101, CRC error count unchanged, read counter increments.
- Same as the loop scenario with crc_err_inj=1 for one frame -> master CRC error count +1, position register not updated. The next frame is clean.
- Master stops clocking after 10 rising edges -> after 150 clocks, abort_cnt=1, ssi_d=1, busy=0. The next full frame is correct.
- position_in changed to 19'h7FFFF at bit 5 of a frame -> the current frame carries the old value, the next frame carries 19'h7FFFF.
- enable=0 with a running master -> ssi_d stays 1, counters unchanged. Reset asserted at bit 14 -> ssi_d=1 asynchronously, all counters 0.

Source files
------------

// File: rtl/ssi_encoder_emulator_pkg.sv
// ssi_encoder_emulator_pkg: shared SSI frame constants, FSM encodings and CRC helpers.
package ssi_encoder_emulator_pkg;
    localparam int SSI_FRAME_BITS = 28;
    localparam int SSI_POS_BITS = 19;
    localparam int SSI_STATUS_BITS = 3;
    localparam logic [5:0] SSI_CRC_SEED = 6'h01;
    localparam logic [1:0] SSI_EMU_IDLE = 2'd0;
    localparam logic [1:0] SSI_EMU_LATCHED = 2'd1;
    localparam logic [1:0] SSI_EMU_SHIFT = 2'd2;
    localparam logic [1:0] SSI_EMU_MONO = 2'd3;

    function automatic logic [5:0] nextCRCx43_D1(input logic d, input logic [5:0] c);
        return {c[4:1], c[0] ^ c[5] ^ d, c[5] ^ d};
    endfunction

    // Data MSB first, CRC sent inverted; inj flips the last CRC bit.
    function automatic logic [27:0] ssi_build_frame(input logic [21:0] data, input logic inj,
                                                    input logic [5:0] seed);
        logic [5:0] c;
        c = seed;
        for (int i = 21; i >= 0; i--) c = nextCRCx43_D1(data[i], c);
        return {data, ~c ^ {5'b0, inj}};
    endfunction
endpackage

// File: rtl/ssi_encoder_emulator_if.sv
// ssi_encoder_emulator_if: SSI pins plus the register-side controls and counters.
interface ssi_encoder_emulator_if
    import ssi_encoder_emulator_pkg::*;
    ;
    logic enable;
    logic [SSI_POS_BITS-1:0] position_in;
    logic [SSI_STATUS_BITS-1:0] status_in;
    logic crc_err_inj;
    logic ssi_c;
    logic ssi_d;
    logic busy;
    logic [15:0] frame_cnt;
    logic [15:0] abort_cnt;

    modport master (
        output enable, position_in, status_in, crc_err_inj, ssi_c,
        input ssi_d, busy, frame_cnt, abort_cnt
    );
    modport slave (
        input enable, position_in, status_in, crc_err_inj, ssi_c,
        output ssi_d, busy, frame_cnt, abort_cnt
    );
endinterface

// File: rtl/ssi_encoder_emulator_ssi_edge_sync.sv
// ssi_edge_sync: 3-FF synchronizer for an idle-high async clock with rise/fall pulses.
module ssi_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic [2:0] s;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) s <= '1;
        else s <= {s[1:0], d};

    assign rise = s[1] & ~s[2];
    assign fall = ~s[1] & s[2];
endmodule

// File: rtl/ssi_encoder_emulator.sv
// ssi_encoder_emulator: SSI slave answering a master clock with a position/status/CRC frame.
module ssi_encoder_emulator
    import ssi_encoder_emulator_pkg::*;
#(
    parameter int FRAME_BITS = SSI_FRAME_BITS,
    parameter int POS_BITS = SSI_POS_BITS,
    parameter int MONOFLOP_TICKS = 150,
    parameter logic [5:0] CRC_SEED = SSI_CRC_SEED
) (
    input logic clk_100m,
    input logic rst_n_syn,
    ssi_encoder_emulator_if.slave bus
);
    logic rise, fall, edge_seen, timeout;
    logic [1:0] state;
    logic [FRAME_BITS-1:0] shift, frame;
    logic [POS_BITS-1:0] pos;
    logic [4:0] idx;
    logic [7:0] mono;
    logic ssi_d_r, busy_r;
    logic [15:0] frame_cnt_r, abort_cnt_r;

    ssi_edge_sync u_sync (
        .clk(clk_100m), .rst_n(rst_n_syn), .d(bus.ssi_c), .rise(rise), .fall(fall)
    );

    assign pos = bus.position_in;
    assign frame = ssi_build_frame({pos, bus.status_in}, bus.crc_err_inj, CRC_SEED);
    assign edge_seen = rise | fall;
    // An edge in the same clock as expiry wins and reloads the monoflop.
    assign timeout = !edge_seen && mono == 8'd0;

    always_ff @(posedge clk_100m or negedge rst_n_syn)
        if (!rst_n_syn) begin
            state <= SSI_EMU_IDLE;
            shift <= '0;
            idx <= '0;
            mono <= '0;
            ssi_d_r <= 1'b1;
            busy_r <= 1'b0;
            frame_cnt_r <= '0;
            abort_cnt_r <= '0;
        end else if (!bus.enable) begin
            if (state != SSI_EMU_IDLE) abort_cnt_r <= abort_cnt_r + 16'd1;
            state <= SSI_EMU_IDLE;
            ssi_d_r <= 1'b1;
            busy_r <= 1'b0;
        end else begin
            mono <= edge_seen ? 8'(MONOFLOP_TICKS) :
                    (state != SSI_EMU_IDLE && mono != 8'd0) ? mono - 8'd1 : mono;
            case (state)
                SSI_EMU_IDLE: if (fall) begin
                    state <= SSI_EMU_LATCHED;
                    shift <= frame;
                    idx <= 5'(FRAME_BITS - 1);
                    busy_r <= 1'b1;
                end
                SSI_EMU_LATCHED: if (rise) begin
                    ssi_d_r <= shift[idx];
                    state <= SSI_EMU_SHIFT;
                end else if (timeout) begin
                    ssi_d_r <= 1'b0;
                    abort_cnt_r <= abort_cnt_r + 16'd1;
                    state <= SSI_EMU_MONO;
                end
                SSI_EMU_SHIFT: if (rise) begin
                    if (idx == 5'd0) begin
                        ssi_d_r <= 1'b0;
                        frame_cnt_r <= frame_cnt_r + 16'd1;
                        state <= SSI_EMU_MONO;
                    end else begin
                        idx <= idx - 5'd1;
                        ssi_d_r <= shift[idx - 5'd1];
                    end
                end else if (timeout) begin
                    ssi_d_r <= 1'b0;
                    abort_cnt_r <= abort_cnt_r + 16'd1;
                    state <= SSI_EMU_MONO;
                end
                default: if (timeout) begin
                    ssi_d_r <= 1'b1;
                    busy_r <= 1'b0;
                    state <= SSI_EMU_IDLE;
                end
            endcase
        end

    assign bus.ssi_d = ssi_d_r;
    assign bus.busy = busy_r;
    assign bus.frame_cnt = frame_cnt_r;
    assign bus.abort_cnt = abort_cnt_r;
endmodule
